// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer and its tick prescaler.
package song_pkg;

    typedef logic [6:0]  pitch_t;
    typedef logic [10:0] index_t;
    typedef logic [7:0]  dur_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    localparam dur_t END_DUR = 8'd0;

    // A zero duration in the ROM marks the end of the song.
    function automatic logic is_end_marker(input dur_t dur);
        return (dur == END_DUR);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Duration-tick prescaler: pulses once every TICK_CYCLES clocks while not cleared.
module tick_gen #(
    parameter int TICK_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(TICK_CYCLES - 1));
    assign tick   = w_wrap && !clear;

    // Free-running count that restarts on wrap or whenever the sequencer is not holding a note.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Steps the song ROMs note by note, holding each pitch for its programmed number of ticks.
module song_sequencer
    import song_pkg::*;
#(
    parameter int TICK_CYCLES = 500000,
    parameter int MAX_NOTES   = 2048
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         play,
    input  logic         stop,
    input  logic         loop,
    output logic [10:0]  note_index,
    input  logic [6:0]   note_pitch,
    input  logic [7:0]   note_dur,
    output logic [6:0]   pitch_out,
    output logic         note_on,
    output logic         playing,
    output logic         done
);

    localparam index_t LAST_INDEX = index_t'(MAX_NOTES - 1);

    seq_state_t r_state;
    index_t     r_index;
    pitch_t     r_pitch;
    dur_t       r_dur_cnt;
    logic       r_note_on;
    logic       r_playing;
    logic       r_done;
    logic       w_tick;
    logic       w_clear;

    // The prescaler only runs in HOLD, so every note starts a fresh tick period.
    assign w_clear = stop || (r_state != ST_HOLD);

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_index   <= 11'd0;
            r_pitch   <= 7'd0;
            r_dur_cnt <= 8'd0;
            r_note_on <= 1'b0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else if (stop) begin
            r_state   <= ST_IDLE;
            r_index   <= 11'd0;
            r_pitch   <= 7'd0;
            r_dur_cnt <= 8'd0;
            r_note_on <= 1'b0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_index   <= 11'd0;
                    r_pitch   <= 7'd0;
                    r_note_on <= 1'b0;
                    if (play) begin
                        r_state   <= ST_LOAD;
                        r_playing <= 1'b1;
                    end else begin
                        r_playing <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (is_end_marker(note_dur)) begin
                        if (loop) begin
                            r_index <= 11'd0;
                        end else begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_index   <= 11'd0;
                            r_pitch   <= 7'd0;
                            r_note_on <= 1'b0;
                            r_playing <= 1'b0;
                        end
                    end else begin
                        r_pitch   <= note_pitch;
                        r_note_on <= (note_pitch != 7'd0);
                        r_dur_cnt <= note_dur;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_dur_cnt <= r_dur_cnt - 8'd1;
                        if (r_dur_cnt == 8'd1) begin
                            // Pitch stays on the line through LOAD; only the gate drops.
                            r_note_on <= 1'b0;
                            if (r_index == LAST_INDEX) begin
                                if (loop) begin
                                    r_index <= 11'd0;
                                    r_state <= ST_LOAD;
                                end else begin
                                    r_state   <= ST_DONE;
                                    r_done    <= 1'b1;
                                    r_index   <= 11'd0;
                                    r_pitch   <= 7'd0;
                                    r_playing <= 1'b0;
                                end
                            end else begin
                                r_index <= r_index + 11'd1;
                                r_state <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign note_index = r_index;
    assign pitch_out  = r_pitch;
    assign note_on    = r_note_on;
    assign playing    = r_playing;
    assign done       = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: a trace model of the song schedule checked every cycle, plus literal pins.
module tb_song_sequencer;

    localparam int TICK = 4;
    localparam int MAXN = 4;

    typedef struct packed {
        logic [10:0] idx;
        logic [6:0]  pitch;
        logic        on;
        logic        pl;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [10:0] note_index;
    logic [6:0]  note_pitch;
    logic [7:0]  note_dur;
    logic [6:0]  pitch_out;
    logic        note_on;
    logic        playing;
    logic        done;

    logic [6:0]  rom_pitch [4];
    logic [7:0]  rom_dur   [4];

    exp_t exp_q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;

    song_sequencer #(
        .TICK_CYCLES (TICK),
        .MAX_NOTES   (MAXN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .stop       (stop),
        .loop       (loop),
        .note_index (note_index),
        .note_pitch (note_pitch),
        .note_dur   (note_dur),
        .pitch_out  (pitch_out),
        .note_on    (note_on),
        .playing    (playing),
        .done       (done)
    );

    assign note_pitch = rom_pitch[note_index[1:0]];
    assign note_dur   = rom_dur[note_index[1:0]];

    always #5 clk = ~clk;

    function automatic exp_t mk(input int idx, input int p, input bit on, input bit pl, input bit dn);
        exp_t e;
        e.idx   = 11'(idx);
        e.pitch = 7'(p);
        e.on    = on;
        e.pl    = pl;
        e.dn    = dn;
        return e;
    endfunction

    // Expected output after each clock edge from the play edge on, built from the note list.
    task automatic gen_song(input bit lp);
        int i;
        int p;
        int guard;
        i = 0;
        p = 0;
        guard = 0;
        while (guard < 300) begin
            exp_q.push_back(mk(i, p, 1'b0, 1'b1, 1'b0));
            guard++;
            if (rom_dur[i] == 8'd0) begin
                if (lp) begin
                    i = 0;
                end else begin
                    exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1));
                    return;
                end
            end else begin
                p = int'(rom_pitch[i]);
                for (int k = 0; k < int'(rom_dur[i]) * TICK; k++) begin
                    exp_q.push_back(mk(i, p, (p != 0), 1'b1, 1'b0));
                    guard++;
                end
                if (i == MAXN - 1) begin
                    if (lp) begin
                        i = 0;
                    end else begin
                        exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1));
                        return;
                    end
                end else begin
                    i++;
                end
            end
        end
    endtask

    // Per-cycle comparison; an empty trace means the block must be idle.
    always @(negedge clk) begin
        if (cmp_en) begin
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : mk(0, 0, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({note_index, pitch_out, note_on, playing, done} !== cur) begin
                errors++;
                $display("FAIL trace t=%0t got idx=%0d pitch=%0d on=%b playing=%b done=%b want idx=%0d pitch=%0d on=%b playing=%b done=%b",
                         $time, note_index, pitch_out, note_on, playing, done,
                         cur.idx, cur.pitch, cur.on, cur.pl, cur.dn);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    task automatic start_song(input bit lp);
        loop = lp;
        play = 1'b1;
        gen_song(lp);
        step(1);
        play = 1'b0;
    endtask

    task automatic abort(input bit use_reset);
        if (use_reset) reset = 1'b1;
        else           stop  = 1'b1;
        exp_q.delete();
        step(1);
        reset = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        rom_pitch[0] = 7'd77; rom_dur[0] = 8'd2;
        rom_pitch[1] = 7'd0;  rom_dur[1] = 8'd1;
        rom_pitch[2] = 7'd75; rom_dur[2] = 8'd3;
        rom_pitch[3] = 7'd0;  rom_dur[3] = 8'd0;

        step(1);
        cmp_en = 1'b1;
        step(2);
        check_lit("reset_pitch", int'(pitch_out), 0);
        check_lit("reset_playing", int'(playing), 0);
        reset = 1'b0;
        step(2);

        // Basic play
        start_song(1'b0);
        check_lit("basic_load_playing", int'(playing), 1);
        check_lit("basic_load_on", int'(note_on), 0);
        step(1);
        check_lit("basic_p2_pitch", int'(pitch_out), 77);
        check_lit("basic_p2_on", int'(note_on), 1);
        step(8);
        check_lit("basic_p10_idx", int'(note_index), 1);
        check_lit("basic_p10_on", int'(note_on), 0);
        step(1);
        check_lit("basic_p11_pitch", int'(pitch_out), 0);
        step(5);
        check_lit("basic_p16_pitch", int'(pitch_out), 75);
        step(12);
        check_lit("basic_p28_idx", int'(note_index), 3);
        step(1);
        check_lit("basic_done", int'(done), 1);
        step(1);
        check_lit("basic_done_clear", int'(done), 0);
        check_lit("basic_idle_pitch", int'(pitch_out), 0);
        step(3);

        // Loop
        start_song(1'b1);
        step(28);
        check_lit("loop_idx0", int'(note_index), 0);
        check_lit("loop_no_done", int'(done), 0);
        step(1);
        check_lit("loop_pitch77", int'(pitch_out), 77);
        step(5);
        abort(1'b0);
        loop = 1'b0;
        step(2);

        // Stop mid-note
        start_song(1'b0);
        step(19);
        check_lit("stop_pre_pitch", int'(pitch_out), 75);
        abort(1'b0);
        check_lit("stop_pitch", int'(pitch_out), 0);
        check_lit("stop_playing", int'(playing), 0);
        check_lit("stop_idx", int'(note_index), 0);
        check_lit("stop_done", int'(done), 0);
        step(3);

        // play and stop together in IDLE
        play = 1'b1;
        stop = 1'b1;
        step(1);
        play = 1'b0;
        stop = 1'b0;
        check_lit("playstop_idle", int'(playing), 0);
        step(2);

        // play pulse during HOLD is ignored
        start_song(1'b0);
        step(4);
        play = 1'b1;
        step(1);
        play = 1'b0;
        step(30);

        // Reset mid-note
        start_song(1'b0);
        step(4);
        abort(1'b1);
        check_lit("rst_mid_pitch", int'(pitch_out), 0);
        check_lit("rst_mid_on", int'(note_on), 0);
        step(2);

        // Index boundary: last ROM slot holds a real note
        rom_pitch[3] = 7'd60;
        rom_dur[3]   = 8'd2;
        start_song(1'b0);
        step(28);
        check_lit("bound_pitch60", int'(pitch_out), 60);
        step(8);
        check_lit("bound_done", int'(done), 1);
        step(2);

        start_song(1'b1);
        step(36);
        check_lit("bound_loop_idx", int'(note_index), 0);
        check_lit("bound_loop_done", int'(done), 0);
        step(1);
        check_lit("bound_loop_pitch", int'(pitch_out), 77);
        abort(1'b0);
        loop = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
